// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared encodings for the multi-cycle RV32I control unit:
//                FSM state codes, ALU control codes, opcodes and the
//                datapath mux / immediate-format select values.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // FSM state codes (4-bit)
    typedef logic [3:0] state_t;

    localparam state_t C_S_FETCH     = 4'd0;
    localparam state_t C_S_DECODE    = 4'd1;
    localparam state_t C_S_MEM_ADR   = 4'd2;
    localparam state_t C_S_MEM_READ  = 4'd3;
    localparam state_t C_S_MEM_WB    = 4'd4;
    localparam state_t C_S_MEM_WRITE = 4'd5;
    localparam state_t C_S_EXEC_R    = 4'd6;
    localparam state_t C_S_EXEC_I    = 4'd7;
    localparam state_t C_S_ALU_WB    = 4'd8;
    localparam state_t C_S_BRANCH    = 4'd9;
    localparam state_t C_S_JAL       = 4'd10;
    localparam state_t C_S_LUI       = 4'd11;
    localparam state_t C_S_TRAP      = 4'd12;

    // ALU control codes
    localparam logic [3:0] C_ALU_ADD = 4'b0000;
    localparam logic [3:0] C_ALU_SUB = 4'b0001;
    localparam logic [3:0] C_ALU_AND = 4'b0010;
    localparam logic [3:0] C_ALU_OR  = 4'b0011;
    localparam logic [3:0] C_ALU_XOR = 4'b0100;
    localparam logic [3:0] C_ALU_SLL = 4'b0101;
    localparam logic [3:0] C_ALU_SRL = 4'b0110;

    // Opcodes of the supported subset
    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_LUI    = 7'b0110111;

    // ALU operand A select
    localparam logic [1:0] C_A_PC    = 2'b00;
    localparam logic [1:0] C_A_OLDPC = 2'b01;
    localparam logic [1:0] C_A_RS1   = 2'b10;
    localparam logic [1:0] C_A_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] C_B_RS2  = 2'b00;
    localparam logic [1:0] C_B_IMM  = 2'b01;
    localparam logic [1:0] C_B_FOUR = 2'b10;

    // Result bus select
    localparam logic [1:0] C_RES_ALUOUT = 2'b00;
    localparam logic [1:0] C_RES_DATA   = 2'b01;
    localparam logic [1:0] C_RES_ALU    = 2'b10;

    // Immediate format select
    localparam logic [2:0] C_IMM_I = 3'b000;
    localparam logic [2:0] C_IMM_S = 3'b001;
    localparam logic [2:0] C_IMM_B = 3'b010;
    localparam logic [2:0] C_IMM_J = 3'b011;
    localparam logic [2:0] C_IMM_U = 3'b100;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder
//  Description : Combinational funct decode for R-type and I-type ALU ops.
//                Produces the ALU control code and whether the funct
//                combination belongs to the supported subset.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic       is_rtype,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_ctrl,
    output logic       legal
);

    // Map funct fields to an ALU operation; instr[30] selects sub only for
    // R-type and must be clear for shifts (no sra/srai support).
    always_comb begin
        alu_ctrl = C_ALU_ADD;
        legal    = 1'b0;
        case (funct3)
            3'b000: begin
                legal    = 1'b1;
                alu_ctrl = (is_rtype && funct7_5) ? C_ALU_SUB : C_ALU_ADD;
            end
            3'b111: begin
                legal    = 1'b1;
                alu_ctrl = C_ALU_AND;
            end
            3'b110: begin
                legal    = 1'b1;
                alu_ctrl = C_ALU_OR;
            end
            3'b100: begin
                legal    = 1'b1;
                alu_ctrl = C_ALU_XOR;
            end
            3'b001: begin
                legal    = ~funct7_5;
                alu_ctrl = C_ALU_SLL;
            end
            3'b101: begin
                legal    = ~funct7_5;
                alu_ctrl = C_ALU_SRL;
            end
            default: begin
                legal    = 1'b0;
                alu_ctrl = C_ALU_ADD;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Moore-FSM control unit for a multi-cycle RV32I datapath.
//                Decodes the instruction register fields and drives mux
//                selects, register-file / memory strobes and the ALU code.
//                Unsupported encodings park the FSM in a sticky TRAP state.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_update,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic [3:0] alu_ctrl,
    output logic       illegal_instr
);

    state_t     r_state;
    state_t     w_next;

    logic [3:0] w_dec_alu;
    logic       w_dec_legal;
    logic       w_is_rtype;

    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_pc_update;
    logic       w_reg_write;

    assign w_is_rtype = (op == C_OP_RTYPE);

    alu_decoder u_alu_decoder (
        .is_rtype (w_is_rtype),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_ctrl (w_dec_alu),
        .legal    (w_dec_legal)
    );

    // State register; reset returns to FETCH and abandons any memory request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= C_S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic, including legality checks performed in DECODE
    always_comb begin
        w_next = r_state;
        case (r_state)
            C_S_FETCH: begin
                if (mem_ready) begin
                    w_next = C_S_DECODE;
                end
            end
            C_S_DECODE: begin
                case (op)
                    C_OP_LOAD,
                    C_OP_STORE:  w_next = (funct3 == 3'b010) ? C_S_MEM_ADR : C_S_TRAP;
                    C_OP_RTYPE:  w_next = w_dec_legal ? C_S_EXEC_R : C_S_TRAP;
                    C_OP_ITYPE:  w_next = w_dec_legal ? C_S_EXEC_I : C_S_TRAP;
                    C_OP_BRANCH: w_next = (funct3[2:1] == 2'b00) ? C_S_BRANCH : C_S_TRAP;
                    C_OP_JAL:    w_next = C_S_JAL;
                    C_OP_LUI:    w_next = C_S_LUI;
                    default:     w_next = C_S_TRAP;
                endcase
            end
            C_S_MEM_ADR:   w_next = (op == C_OP_LOAD) ? C_S_MEM_READ : C_S_MEM_WRITE;
            C_S_MEM_READ: begin
                if (mem_ready) begin
                    w_next = C_S_MEM_WB;
                end
            end
            C_S_MEM_WB:    w_next = C_S_FETCH;
            C_S_MEM_WRITE: begin
                if (mem_ready) begin
                    w_next = C_S_FETCH;
                end
            end
            C_S_EXEC_R:    w_next = C_S_ALU_WB;
            C_S_EXEC_I:    w_next = C_S_ALU_WB;
            C_S_ALU_WB:    w_next = C_S_FETCH;
            C_S_BRANCH:    w_next = C_S_FETCH;
            C_S_JAL:       w_next = C_S_ALU_WB;
            C_S_LUI:       w_next = C_S_ALU_WB;
            C_S_TRAP:      w_next = C_S_TRAP;
            default:       w_next = C_S_FETCH;
        endcase
    end

    // Moore output decode; only FETCH/BRANCH look at mem_ready/zero
    always_comb begin
        w_mem_req     = 1'b0;
        w_mem_write   = 1'b0;
        adr_src       = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_update   = 1'b0;
        w_reg_write   = 1'b0;
        alu_src_a     = C_A_PC;
        alu_src_b     = C_B_RS2;
        result_src    = C_RES_ALUOUT;
        alu_ctrl      = C_ALU_ADD;
        illegal_instr = 1'b0;
        case (r_state)
            C_S_FETCH: begin
                w_mem_req   = 1'b1;
                alu_src_a   = C_A_PC;
                alu_src_b   = C_B_FOUR;
                result_src  = C_RES_ALU;
                w_ir_write  = mem_ready;
                w_pc_update = mem_ready;
            end
            C_S_DECODE: begin
                alu_src_a = C_A_OLDPC;
                alu_src_b = C_B_IMM;
            end
            C_S_MEM_ADR: begin
                alu_src_a = C_A_RS1;
                alu_src_b = C_B_IMM;
            end
            C_S_MEM_READ: begin
                w_mem_req = 1'b1;
                adr_src   = 1'b1;
            end
            C_S_MEM_WB: begin
                result_src  = C_RES_DATA;
                w_reg_write = 1'b1;
            end
            C_S_MEM_WRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                adr_src     = 1'b1;
            end
            C_S_EXEC_R: begin
                alu_src_a = C_A_RS1;
                alu_src_b = C_B_RS2;
                alu_ctrl  = w_dec_alu;
            end
            C_S_EXEC_I: begin
                alu_src_a = C_A_RS1;
                alu_src_b = C_B_IMM;
                alu_ctrl  = w_dec_alu;
            end
            C_S_ALU_WB: begin
                result_src  = C_RES_ALUOUT;
                w_reg_write = 1'b1;
            end
            C_S_BRANCH: begin
                alu_src_a   = C_A_RS1;
                alu_src_b   = C_B_RS2;
                alu_ctrl    = C_ALU_SUB;
                result_src  = C_RES_ALUOUT;
                w_pc_update = funct3[0] ? ~zero : zero;
            end
            C_S_JAL: begin
                alu_src_a   = C_A_OLDPC;
                alu_src_b   = C_B_FOUR;
                result_src  = C_RES_ALUOUT;
                w_pc_update = 1'b1;
            end
            C_S_LUI: begin
                alu_src_a = C_A_ZERO;
                alu_src_b = C_B_IMM;
            end
            C_S_TRAP: begin
                illegal_instr = 1'b1;
            end
            default: begin
                illegal_instr = 1'b0;
            end
        endcase
    end

    // Strobes are suppressed for the whole time rst is asserted
    assign mem_req   = w_mem_req   & ~rst;
    assign mem_write = w_mem_write & ~rst;
    assign ir_write  = w_ir_write  & ~rst;
    assign pc_update = w_pc_update & ~rst;
    assign reg_write = w_reg_write & ~rst;

    // Immediate format follows the opcode directly
    always_comb begin
        case (op)
            C_OP_STORE:  imm_src = C_IMM_S;
            C_OP_BRANCH: imm_src = C_IMM_B;
            C_OP_JAL:    imm_src = C_IMM_J;
            C_OP_LUI:    imm_src = C_IMM_U;
            default:     imm_src = C_IMM_I;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl. Each instruction is
//                expanded into a list of expected bus-level phases from the
//                instruction's class; randomized memory stalls and zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_ctrl;
    logic       illegal_instr;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_update     (pc_update),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .imm_src       (imm_src),
        .alu_ctrl      (alu_ctrl),
        .illegal_instr (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Bus-level phases an instruction passes through
    typedef enum int {
        K_FETCH, K_DEC, K_ADDR, K_RD, K_LDWB, K_WR,
        K_EXR, K_EXI, K_WB, K_BR, K_JAL, K_LUI, K_TRAP
    } kind_t;

    // Instruction legality of the supported subset
    function automatic bit ref_legal(logic [6:0] o, logic [2:0] f3, logic f75);
        case (o)
            7'h03, 7'h23: return (f3 == 3'd2);
            7'h63:        return (f3 == 3'd0) || (f3 == 3'd1);
            7'h6f, 7'h37: return 1'b1;
            7'h33, 7'h13: return (f3 == 3'd0) || (f3 == 3'd4) || (f3 == 3'd6) || (f3 == 3'd7)
                                 || (((f3 == 3'd1) || (f3 == 3'd5)) && !f75);
            default:      return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ref_alu(bit is_r, logic [2:0] f3, logic f75);
        case (f3)
            3'd0:    return (is_r && f75) ? 4'd1 : 4'd0;
            3'd7:    return 4'd2;
            3'd6:    return 4'd3;
            3'd4:    return 4'd4;
            3'd1:    return 4'd5;
            3'd5:    return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [2:0] ref_imm(logic [6:0] o);
        case (o)
            7'h23:   return 3'd1;
            7'h63:   return 3'd2;
            7'h6f:   return 3'd3;
            7'h37:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Expected {mem_req,mem_write,adr_src,ir_write,pc_update,reg_write,a,b,res,alu,illegal}
    function automatic logic [16:0] exp_step(kind_t k, logic mr, logic z,
                                             logic [6:0] o, logic [2:0] f3, logic f75);
        logic       mq = 1'b0, mw = 1'b0, as = 1'b0, irw = 1'b0;
        logic       pcu = 1'b0, rw = 1'b0, ill = 1'b0;
        logic [1:0] a = 2'd0, b = 2'd0, rs = 2'd0;
        logic [3:0] alu = 4'd0;
        case (k)
            K_FETCH: begin mq = 1'b1; b = 2'd2; rs = 2'd2; irw = mr; pcu = mr; end
            K_DEC:   begin a = 2'd1; b = 2'd1; end
            K_ADDR:  begin a = 2'd2; b = 2'd1; end
            K_RD:    begin mq = 1'b1; as = 1'b1; end
            K_LDWB:  begin rs = 2'd1; rw = 1'b1; end
            K_WR:    begin mq = 1'b1; mw = 1'b1; as = 1'b1; end
            K_EXR:   begin a = 2'd2; alu = ref_alu(1'b1, f3, f75); end
            K_EXI:   begin a = 2'd2; b = 2'd1; alu = ref_alu(1'b0, f3, f75); end
            K_WB:    begin rw = 1'b1; end
            K_BR:    begin a = 2'd2; alu = 4'd1; pcu = (f3 == 3'd0) ? z : !z; end
            K_JAL:   begin a = 2'd1; b = 2'd2; pcu = 1'b1; end
            K_LUI:   begin a = 2'd3; b = 2'd1; end
            K_TRAP:  begin ill = 1'b1; end
            default: begin end
        endcase
        return {mq, mw, as, irw, pcu, rw, a, b, rs, alu, ill};
    endfunction

    // Run one instruction from FETCH to its last phase, checking every cycle
    task automatic run_instr(input logic [31:0] instr, input int fst, input int mst,
                             input logic zv, input int trap_n,
                             output int wb_cycle, output int ncyc);
        kind_t       plan[$];
        kind_t       k;
        logic [6:0]  o;
        logic [2:0]  f3;
        logic        f75;
        logic        mr;
        logic [16:0] expv;
        logic [16:0] got;
        int          cyc;
        o   = instr[6:0];
        f3  = instr[14:12];
        f75 = instr[30];
        plan.push_back(K_FETCH);
        plan.push_back(K_DEC);
        if (!ref_legal(o, f3, f75)) begin
            for (int i = 0; i < trap_n; i++) plan.push_back(K_TRAP);
        end else begin
            case (o)
                7'h03: begin plan.push_back(K_ADDR); plan.push_back(K_RD); plan.push_back(K_LDWB); end
                7'h23: begin plan.push_back(K_ADDR); plan.push_back(K_WR); end
                7'h33: begin plan.push_back(K_EXR); plan.push_back(K_WB); end
                7'h13: begin plan.push_back(K_EXI); plan.push_back(K_WB); end
                7'h63: begin plan.push_back(K_BR); end
                7'h6f: begin plan.push_back(K_JAL); plan.push_back(K_WB); end
                default: begin plan.push_back(K_LUI); plan.push_back(K_WB); end
            endcase
        end
        cyc      = 0;
        wb_cycle = 0;
        while (plan.size() > 0) begin
            k = plan[0];
            @(negedge clk);
            if (cyc == 0) begin
                op       = o;
                funct3   = f3;
                funct7_5 = f75;
            end
            if (k == K_FETCH) begin
                mr = (fst > 0) ? 1'b0 : 1'b1;
                if (!mr) fst--;
            end else if (k == K_RD || k == K_WR) begin
                mr = (mst > 0) ? 1'b0 : 1'b1;
                if (!mr) mst--;
            end else begin
                mr = 1'($urandom_range(0, 1));
            end
            mem_ready = mr;
            zero      = (k == K_BR) ? zv : 1'($urandom_range(0, 1));
            #1;
            cyc++;
            expv = exp_step(k, mr, zero, o, f3, f75);
            got  = {mem_req, mem_write, adr_src, ir_write, pc_update, reg_write,
                    alu_src_a, alu_src_b, result_src, alu_ctrl, illegal_instr};
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL outputs instr=%08h phase=%0d cyc=%0d got=%05h expected=%05h",
                         instr, k, cyc, got, expv);
            end
            checks++;
            if (imm_src !== ref_imm(o)) begin
                errors++;
                $display("FAIL imm_src instr=%08h got=%0d expected=%0d", instr, imm_src, ref_imm(o));
            end
            if (reg_write === 1'b1 && wb_cycle == 0) wb_cycle = cyc;
            if (!((k == K_FETCH || k == K_RD || k == K_WR) && !mr)) void'(plan.pop_front());
        end
        ncyc = cyc;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_write, ir_write, pc_update, reg_write, illegal_instr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes got=%06b expected=000000",
                     {mem_req, mem_write, ir_write, pc_update, reg_write, illegal_instr});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_req, adr_src, ir_write, illegal_instr} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_release got=%04b expected=1000",
                     {mem_req, adr_src, ir_write, illegal_instr});
        end
    endtask

    task automatic test_reset();
        // reset held from time zero
        #1;
        checks++;
        if ({mem_req, mem_write, ir_write, pc_update, reg_write, illegal_instr} !== 6'b0) begin
            errors++;
            $display("FAIL por_strobes got=%06b expected=000000",
                     {mem_req, mem_write, ir_write, pc_update, reg_write, illegal_instr});
        end
        apply_reset();
        // walk an lw into MEM_READ, then abort it asynchronously
        op = 7'h03; funct3 = 3'd2; funct7_5 = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_write, adr_src} !== 3'b101) begin
            errors++;
            $display("FAIL mid_read got=%03b expected=101", {mem_req, mem_write, adr_src});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_write, ir_write, pc_update, reg_write} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset_strobes got=%05b expected=00000",
                     {mem_req, mem_write, ir_write, pc_update, reg_write});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_req, adr_src, alu_src_b, result_src} !== 6'b101010) begin
            errors++;
            $display("FAIL after_abort got=%06b expected=101010",
                     {mem_req, adr_src, alu_src_b, result_src});
        end
    endtask

    task automatic test_alu_ops();
        int wb, n;
        run_instr(32'h002081B3, 0, 0, 1'b0, 0, wb, n);   // add
        checks++;
        if (wb !== 4 || n !== 4) begin
            errors++;
            $display("FAIL add_latency got wb=%0d len=%0d expected wb=4 len=4", wb, n);
        end
        run_instr(32'h402081B3, 0, 0, 1'b0, 0, wb, n);   // sub
        run_instr(32'h0020C1B3, 1, 0, 1'b0, 0, wb, n);   // xor, one fetch stall
        checks++;
        if (wb !== 5) begin
            errors++;
            $display("FAIL xor_stall_latency got=%0d expected=5", wb);
        end
        run_instr(32'h00509093, 0, 0, 1'b0, 0, wb, n);   // slli
        run_instr(32'h4050D093, 0, 0, 1'b0, 0, wb, n);   // srai -> trap (checked per phase)
        apply_reset();
        run_instr(32'h123450B7, 0, 0, 1'b0, 0, wb, n);   // lui
        checks++;
        if (wb !== 4) begin
            errors++;
            $display("FAIL lui_latency got=%0d expected=4", wb);
        end
    endtask

    task automatic test_mem();
        int wb, n;
        run_instr(32'h00012083, 3, 3, 1'b0, 0, wb, n);   // lw with stalls
        checks++;
        if (wb !== 11 || n !== 11) begin
            errors++;
            $display("FAIL lw_stall_latency got wb=%0d len=%0d expected 11", wb, n);
        end
        run_instr(32'h00112023, 0, 0, 1'b0, 0, wb, n);   // sw
        checks++;
        if (n !== 4 || wb !== 0) begin
            errors++;
            $display("FAIL sw_latency got len=%0d wb=%0d expected len=4 wb=0", n, wb);
        end
    endtask

    task automatic test_branch();
        int wb, n;
        run_instr(32'h00208463, 0, 0, 1'b1, 0, wb, n);   // beq taken
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL beq_latency got=%0d expected=3", n);
        end
        run_instr(32'h00209463, 0, 0, 1'b1, 0, wb, n);   // bne not taken
        run_instr(32'h00209463, 0, 0, 1'b0, 0, wb, n);   // bne taken
        run_instr(32'h00208463, 0, 0, 1'b0, 0, wb, n);   // beq not taken
    endtask

    task automatic test_trap();
        int wb, n;
        run_instr(32'h0020A1B3, 0, 0, 1'b0, 20, wb, n);  // slt
        apply_reset();
    endtask

    task automatic test_jal();
        int wb, n;
        run_instr(32'h008000EF, 0, 0, 1'b0, 0, wb, n);
        checks++;
        if (wb !== 4 || n !== 4) begin
            errors++;
            $display("FAIL jal_latency got wb=%0d len=%0d expected 4", wb, n);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [7] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h37};
        logic [31:0] w;
        int          wb, n;
        for (int i = 0; i < 60; i++) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 6)];
            run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 4, wb, n);
            if (!ref_legal(w[6:0], w[14:12], w[30])) apply_reset();
        end
    endtask

    initial begin
        rst       = 1'b1;
        op        = 7'd0;
        funct3    = 3'd0;
        funct7_5  = 1'b0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_alu_ops();
        test_mem();
        test_branch();
        test_trap();
        test_jal();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle RV32I control unit. It decodes the instruction register fields and drives the datapath muxes, register-file/memory strobes and the 4-bit alu_ctrl code consumed by the ALU. It also consumes the ALU zero flag for branches.
- Sits between the instruction register and the datapath.
- Supported subset: lw, sw, R-type add/sub/and/or/xor/sll/srl, I-type addi/andi/ori/xori/slli/srli, beq, bne, jal, lui. Any other encoding traps.

Parameters:
- none (encodings fixed by the shared package)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  request is a store (valid only with mem_req)
- adr_src  out  1  0 = PC, 1 = ALU-out register
- ir_write  out  1  load the instruction register and the old-PC register
- pc_update  out  1  PC <= result bus
- reg_write  out  1  register-file write enable
- alu_src_a  out  2  00 = PC, 01 = old PC, 10 = rs1 register, 11 = zero
- alu_src_b  out  2  00 = rs2 register, 01 = imm_ext, 10 = constant 4
- result_src  out  2  00 = ALU-out register, 01 = data register, 10 = live ALU result
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U; combinational from op, default 000
- alu_ctrl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl
- illegal_instr  out  1  high while in TRAP

Behaviour:
- Moore FSM; all outputs are decoded from state, plus mem_ready/zero where noted.
- Defaults in every state: all strobes 0, all selects 0, alu_ctrl 0000.
- Reset:
  - Async rst forces state FETCH at any time; any in-flight memory request is abandoned.
  - While rst is high, mem_req, mem_write, ir_write, pc_update and reg_write are forced 0.
  - First cycle after release: FETCH with mem_req = 1.
- States:
  - FETCH: mem_req = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, add, result_src = 10. ir_write = pc_update = mem_ready. Stays until mem_ready, then goes to DECODE.
  - DECODE: alu_src_a = 01, alu_src_b = 01, add (precomputes branch/jump target).
    - lw/sw go to MEM_ADR; R-type to EXEC_R; I-ALU to EXEC_I; beq/bne to BRANCH; jal to JAL; lui to LUI.
    - Illegal op, or illegal funct combination, goes to TRAP.
  - MEM_ADR: a = 10, b = 01, add. lw goes to MEM_READ, sw to MEM_WRITE.
  - MEM_READ: mem_req = 1, adr_src = 1. Stays until mem_ready, then goes to MEM_WB.
  - MEM_WB: result_src = 01, reg_write = 1, then FETCH.
  - MEM_WRITE: mem_req = 1, mem_write = 1, adr_src = 1. Stays until mem_ready, then FETCH.
  - EXEC_R: a = 10, b = 00, alu_ctrl from funct decode, then ALU_WB.
  - EXEC_I: a = 10, b = 01, alu_ctrl from funct decode, then ALU_WB.
  - ALU_WB: result_src = 00, reg_write = 1, then FETCH.
  - BRANCH: a = 10, b = 00, sub, result_src = 00. pc_update = zero for beq, !zero for bne. Then FETCH.
  - JAL: a = 01, b = 10, add, result_src = 00, pc_update = 1 (PC <= target held in ALU-out). Then ALU_WB (writes old PC + 4).
  - LUI: a = 11, b = 01, add, then ALU_WB.
  - TRAP: all strobes 0, illegal_instr = 1. Sticky until rst.
- Funct decode, R-type:
  - funct3 000: funct7_5 = 0 gives add, 1 gives sub.
  - funct3 111 gives and; 110 gives or; 100 gives xor.
  - funct3 001 gives sll and 101 gives srl, both only with funct7_5 = 0.
  - funct3 010, 011, and 101 with funct7_5 = 1 are illegal.
- Funct decode, I-type:
  - funct3 000 gives add; funct7_5 is ignored.
  - funct3 111/110/100 give and/or/xor.
  - funct3 001/101 require funct7_5 = 0.
  - funct3 010 and 011 are illegal.
- Other legality rules:
  - lw/sw require funct3 = 010.
  - Branches require funct3 000 or 001.
- Latency in cycles, with mem_ready held high:
  - R/I/lui: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - jal: 4
  - Each mem_ready-low cycle adds 1.

Decomposition:
- Package ctrl_pkg holds:
  - state enum (4-bit)
  - alu_ctrl constants
  - opcode constants
  - src/imm select constants
- Sub-module alu_decoder: combinational {is_rtype, funct3, funct7_5} -> {alu_ctrl, legal}. Used in DECODE for legality and in EXEC_R/EXEC_I for alu_ctrl.

Test Plan:
- Assert rst mid-MEM_READ -> strobes 0 immediately; after release state is FETCH and mem_req = 1 on the first clock.
- add x3,x1,x2 (0x002081B3), mem_ready = 1 -> FETCH, DECODE, EXEC_R (alu_ctrl 0000), ALU_WB with reg_write = 1 in cycle 4. The sub variant (0x402081B3) gives alu_ctrl 0001.
- lw with mem_ready low 3 cycles in FETCH and in MEM_READ -> mem_req held, ir_write pulses only on the ready cycle, reg_write in cycle 11.
- beq with zero = 1 -> pc_update = 1 in BRANCH; bne with zero = 1 -> pc_update = 0; both return to FETCH.
- slt (0x0020A1B3) -> TRAP after DECODE, illegal_instr = 1; no mem_req for 20 cycles; rst clears it.
- jal (0x008000EF) -> JAL (pc_update = 1, a = 01, b = 10), then ALU_WB (reg_write = 1), then FETCH.
